alu_op_sequencer: RTL and testbench

Command-side initiator for the 4-bit combinational ALU (8 opcodes, A/B operands, result plus carry). It holds a small operand register file and accepts register-addressed commands over a valid/ready handshake. It drives registered A/B/opcode to the ALU, captures result and carry, writes the result back, and returns a response over a second valid/ready handshake. It sits between a host or test controller and the ALU instance.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_regfile.sv | 46 ++++
 rtl/alu_op_sequencer.sv | 141 ++++++++++++++
 tb/tb_alu_op_sequencer.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: data width, opcodes,
// FSM state encoding and the response payload.
package alu_pkg;

  localparam int unsigned DATA_W = 4;
  localparam int unsigned OP_W   = 3;
  localparam int unsigned ST_W   = 2;

  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB = 3'b001;
  localparam logic [OP_W-1:0] OP_INC = 3'b010;
  localparam logic [OP_W-1:0] OP_DEC = 3'b011;
  localparam logic [OP_W-1:0] OP_NOT = 3'b100;
  localparam logic [OP_W-1:0] OP_XOR = 3'b101;
  localparam logic [OP_W-1:0] OP_AND = 3'b110;
  localparam logic [OP_W-1:0] OP_OR  = 3'b111;

  localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [ST_W-1:0] ST_ISSUE = 2'd1;
  localparam logic [ST_W-1:0] ST_RESP  = 2'd2;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic              cout;
  } rsp_t;

endpackage

// File: rtl/alu_regfile.sv
// Operand register file: one write port, two operand read ports and a host
// read port, all reads combinational.
module alu_regfile
  import alu_pkg::*;
#(
  parameter int unsigned NREG = 4,
  parameter int unsigned AW   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     ra_addr,
  output logic [DATA_W-1:0] ra_data,
  input  logic [AW-1:0]     rb_addr,
  output logic [DATA_W-1:0] rb_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];

  always_comb begin
    regs_d = regs_q;
    if (we) begin
      regs_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  assign ra_data = regs_q[ra_addr];
  assign rb_data = regs_q[rb_addr];
  assign rd_data = regs_q[rd_addr];

endmodule

// File: rtl/alu_op_sequencer.sv
// Command-side initiator for the 4-bit ALU: reads operands from the register
// file, drives the ALU, writes the result back and returns a response.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned NREG = 4,
  parameter int unsigned AW   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [AW-1:0]     cmd_srca,
  input  logic [AW-1:0]     cmd_srcb,
  input  logic [AW-1:0]     cmd_dst,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_cout,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_cout,
  output logic              busy
);

  logic [ST_W-1:0]   state_q, state_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [OP_W-1:0]   alu_op_q, alu_op_d;
  logic [AW-1:0]     dst_q, dst_d;
  rsp_t              rsp_q, rsp_d;
  logic              rsp_valid_q, rsp_valid_d;

  logic              rf_we;
  logic [AW-1:0]     rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [DATA_W-1:0] ra_data, rb_data;

  alu_regfile #(
    .NREG (NREG),
    .AW   (AW)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata),
    .ra_addr (cmd_srca),
    .ra_data (ra_data),
    .rb_addr (cmd_srcb),
    .rb_data (rb_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Host writes win over a command presented in the same IDLE cycle.
  assign cmd_ready = (state_q == ST_IDLE) && !wr_en;

  always_comb begin
    state_d     = state_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    dst_d       = dst_q;
    rsp_d       = rsp_q;
    rsp_valid_d = rsp_valid_q;
    rf_we       = 1'b0;
    rf_waddr    = wr_addr;
    rf_wdata    = wr_data;

    case (state_q)
      ST_IDLE: begin
        if (wr_en) begin
          rf_we = 1'b1;
        end else if (cmd_valid) begin
          alu_a_d  = ra_data;
          alu_b_d  = rb_data;
          alu_op_d = cmd_op;
          dst_d    = cmd_dst;
          state_d  = ST_ISSUE;
        end
      end
      // ALU output has settled from the registered operands; capture and write back.
      ST_ISSUE: begin
        rf_we       = 1'b1;
        rf_waddr    = dst_q;
        rf_wdata    = alu_result;
        rsp_d       = '{result: alu_result, cout: alu_cout};
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= OP_ADD;
      dst_q       <= '0;
      rsp_q       <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      dst_q       <= dst_d;
      rsp_q       <= rsp_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_q.result;
  assign rsp_cout   = rsp_q.cout;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: an ALU model closes the loop, and directed plus
// random scenarios are checked against an integer reference model.
module tb_alu_op_sequencer;

  localparam int unsigned DW = 4;
  localparam int unsigned AWT = 2;
  localparam int unsigned NR = 4;
  localparam int unsigned NCMD = 1000;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           wr_en = 1'b0;
  logic [AWT-1:0] wr_addr = '0;
  logic [DW-1:0]  wr_data = '0;
  logic [AWT-1:0] rd_addr = '0;
  logic [DW-1:0]  rd_data;
  logic           cmd_valid = 1'b0;
  logic           cmd_ready;
  logic [2:0]     cmd_op = '0;
  logic [AWT-1:0] cmd_srca = '0;
  logic [AWT-1:0] cmd_srcb = '0;
  logic [AWT-1:0] cmd_dst = '0;
  logic [DW-1:0]  alu_a, alu_b, alu_result;
  logic [2:0]     alu_op;
  logic           alu_cout;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic [DW-1:0]  rsp_result;
  logic           rsp_cout;
  logic           busy;

  int checks = 0;
  int failures = 0;
  int ref_r [NR];

  always #5 clk = ~clk;

  alu_op_sequencer #(.NREG(NR), .AW(AWT)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_srca(cmd_srca), .cmd_srcb(cmd_srcb), .cmd_dst(cmd_dst),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_cout(alu_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_cout(rsp_cout), .busy(busy)
  );

  // Combinational 4-bit ALU; SUB/DEC carry is the borrow.
  logic [4:0] alu_tmp;
  always_comb begin
    alu_tmp = '0;
    case (alu_op)
      3'd0: alu_tmp = {1'b0, alu_a} + {1'b0, alu_b};
      3'd1: alu_tmp = {1'b0, alu_a} - {1'b0, alu_b};
      3'd2: alu_tmp = {1'b0, alu_b} + 5'd1;
      3'd3: alu_tmp = {1'b0, alu_b} - 5'd1;
      3'd4: alu_tmp = {1'b0, ~alu_a};
      3'd5: alu_tmp = {1'b0, alu_a ^ alu_b};
      3'd6: alu_tmp = {1'b0, alu_a & alu_b};
      default: alu_tmp = {1'b0, alu_a | alu_b};
    endcase
  end
  assign alu_result = alu_tmp[3:0];
  assign alu_cout   = alu_tmp[4];

  function automatic void ref_alu(input int op, input int a, input int b,
                                  output int res, output int cout);
    int s;
    cout = 0;
    case (op)
      0: begin s = a + b; cout = (s > 15) ? 1 : 0; end
      1: begin s = a - b; cout = (s < 0) ? 1 : 0; end
      2: begin s = b + 1; cout = (s > 15) ? 1 : 0; end
      3: begin s = b - 1; cout = (s < 0) ? 1 : 0; end
      4: s = 15 - a;
      5: s = a ^ b;
      6: s = a & b;
      default: s = a | b;
    endcase
    res = s & 15;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input int addr, input int data);
    wr_en = 1'b1;
    wr_addr = AWT'(addr);
    wr_data = DW'(data);
    step();
    wr_en = 1'b0;
    ref_r[addr] = data;
  endtask

  // Presents a command from IDLE and waits (bounded) for rsp_valid, leaving rsp_ready low.
  task automatic issue_cmd(input int op, input int sa, input int sb, input int d,
                           output int res, output int cout, output int lat);
    cmd_valid = 1'b1;
    cmd_op = 3'(op);
    cmd_srca = AWT'(sa);
    cmd_srcb = AWT'(sb);
    cmd_dst = AWT'(d);
    rsp_ready = 1'b0;
    step();
    cmd_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 10) begin
      step();
      lat++;
    end
    res = int'(rsp_result);
    cout = int'(rsp_cout);
  endtask

  task automatic release_rsp();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < NR; i++) ref_r[i] = 0;
    repeat (2) step();
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1 || alu_op !== 3'd0) begin
      failures++;
      $display("FAIL reset_ctrl got v=%b busy=%b rdy=%b op=%0d exp v=0 busy=0 rdy=1 op=0",
               rsp_valid, busy, cmd_ready, alu_op);
    end
    checks++;
    if (rsp_result !== 4'h0 || rsp_cout !== 1'b0 || alu_a !== 4'h0 || alu_b !== 4'h0) begin
      failures++;
      $display("FAIL reset_data got res=%h cout=%b a=%h b=%h exp all 0",
               rsp_result, rsp_cout, alu_a, alu_b);
    end
    for (int i = 0; i < NR; i++) begin
      rd_addr = AWT'(i);
      #1;
      checks++;
      if (rd_data !== 4'h0) begin
        failures++;
        $display("FAIL reset_reg%0d got=%h exp=0", i, rd_data);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_add_carry();
    int res, cout, lat, er, ec;
    host_write(0, 9);
    host_write(1, 8);
    ref_alu(0, ref_r[0], ref_r[1], er, ec);
    issue_cmd(0, 0, 1, 2, res, cout, lat);
    ref_r[2] = er;
    checks++;
    if (lat !== 1) begin
      failures++;
      $display("FAIL add_latency got=%0d exp=1 edges after accept", lat);
    end
    checks++;
    if (res !== er || cout !== ec || er !== 1) begin
      failures++;
      $display("FAIL add_result got=%h/%0d exp=%h/%0d", res, cout, er, ec);
    end
    release_rsp();
    rd_addr = 2'd2;
    #1;
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0 || rd_data !== DW'(ref_r[2])) begin
      failures++;
      $display("FAIL add_wb got busy=%b v=%b R2=%h exp busy=0 v=0 R2=%h",
               busy, rsp_valid, rd_data, DW'(ref_r[2]));
    end
  endtask

  task automatic test_xor_backpressure();
    int res, cout, lat, er, ec;
    host_write(0, 'hA);
    host_write(1, 'h6);
    ref_alu(5, ref_r[0], ref_r[1], er, ec);
    issue_cmd(5, 0, 1, 3, res, cout, lat);
    ref_r[3] = er;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_result !== DW'(er) || cmd_ready !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL xor_hold%0d got v=%b res=%h rdy=%b busy=%b exp v=1 res=%h rdy=0 busy=1",
                 i, rsp_valid, rsp_result, cmd_ready, busy, DW'(er));
      end
      step();
    end
    release_rsp();
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL xor_release got v=%b busy=%b rdy=%b exp v=0 busy=0 rdy=1",
               rsp_valid, busy, cmd_ready);
    end
  endtask

  task automatic test_inc_chain();
    int res, cout, lat, er, ec;
    host_write(1, 'hF);
    ref_alu(2, ref_r[1], ref_r[1], er, ec);
    issue_cmd(2, 1, 1, 1, res, cout, lat);
    ref_r[1] = er;
    checks++;
    if (res !== er || cout !== ec || er !== 0 || ec !== 1) begin
      failures++;
      $display("FAIL inc_wrap got=%h/%0d exp=%h/%0d", res, cout, er, ec);
    end
    release_rsp();
    ref_alu(4, ref_r[1], ref_r[1], er, ec);
    issue_cmd(4, 1, 1, 0, res, cout, lat);
    ref_r[0] = er;
    checks++;
    if (res !== er || cout !== ec || er !== 'hF) begin
      failures++;
      $display("FAIL not_dep got=%h/%0d exp=%h/%0d", res, cout, er, ec);
    end
    release_rsp();
    rd_addr = 2'd0;
    #1;
    checks++;
    if (rd_data !== 4'hF) begin
      failures++;
      $display("FAIL chain_wb got R0=%h exp=f", rd_data);
    end
  endtask

  task automatic test_write_priority();
    int lat, er, ec;
    wr_en = 1'b1;
    wr_addr = 2'd2;
    wr_data = 4'h5;
    cmd_valid = 1'b1;
    cmd_op = 3'd0;
    cmd_srca = 2'd2;
    cmd_srcb = 2'd2;
    cmd_dst = 2'd3;
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL prio_ready got=%b exp=0", cmd_ready);
    end
    step();
    ref_r[2] = 5;
    wr_en = 1'b0;
    rd_addr = 2'd2;
    #1;
    checks++;
    if (rd_data !== 4'h5 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL prio_write got R2=%h busy=%b rdy=%b exp R2=5 busy=0 rdy=1",
               rd_data, busy, cmd_ready);
    end
    step();
    cmd_valid = 1'b0;
    ref_alu(0, ref_r[2], ref_r[2], er, ec);
    ref_r[3] = er;
    // Now in ISSUE: this write must be dropped.
    wr_en = 1'b1;
    wr_addr = 2'd0;
    wr_data = 4'h7;
    step();
    wr_en = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 10) begin
      step();
      lat++;
    end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_result !== DW'(er) || rsp_cout !== 1'(ec)) begin
      failures++;
      $display("FAIL prio_cmd got v=%b res=%h cout=%b exp v=1 res=%h cout=%0d",
               rsp_valid, rsp_result, rsp_cout, DW'(er), ec);
    end
    release_rsp();
    rd_addr = 2'd0;
    #1;
    checks++;
    if (rd_data !== DW'(ref_r[0])) begin
      failures++;
      $display("FAIL drop_write got R0=%h exp=%h", rd_data, DW'(ref_r[0]));
    end
  endtask

  task automatic test_reset_mid_op();
    int res, cout, lat, er, ec;
    host_write(1, 3);
    issue_cmd(1, 0, 1, 2, res, cout, lat);
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < NR; i++) ref_r[i] = 0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || alu_op !== 3'd0) begin
      failures++;
      $display("FAIL midrst_ctrl got v=%b busy=%b op=%0d exp v=0 busy=0 op=0",
               rsp_valid, busy, alu_op);
    end
    for (int i = 0; i < NR; i++) begin
      rd_addr = AWT'(i);
      #1;
      checks++;
      if (rd_data !== 4'h0) begin
        failures++;
        $display("FAIL midrst_reg%0d got=%h exp=0", i, rd_data);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    host_write(0, 6);
    host_write(3, 2);
    ref_alu(1, ref_r[0], ref_r[3], er, ec);
    issue_cmd(1, 0, 3, 1, res, cout, lat);
    ref_r[1] = er;
    checks++;
    if (res !== er || cout !== ec || lat !== 1) begin
      failures++;
      $display("FAIL midrst_next got=%h/%0d lat=%0d exp=%h/%0d lat=1", res, cout, lat, er, ec);
    end
    release_rsp();
  endtask

  task automatic test_random();
    int ncmd = 0, cyc = 0;
    bit m_busy = 0, m_issue = 0, m_valid = 0;
    int exp_res = 0, exp_cout = 0, res, cout;
    while (ncmd < NCMD && cyc < 20000) begin
      wr_en = ($urandom_range(0, 3) == 0);
      wr_addr = AWT'($urandom_range(0, NR - 1));
      wr_data = DW'($urandom_range(0, 15));
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_op = 3'($urandom_range(0, 7));
      cmd_srca = AWT'($urandom_range(0, NR - 1));
      cmd_srcb = AWT'($urandom_range(0, NR - 1));
      cmd_dst = AWT'($urandom_range(0, NR - 1));
      rsp_ready = ($urandom_range(0, 2) != 0);
      rd_addr = AWT'($urandom_range(0, NR - 1));
      #1;
      checks++;
      if (cmd_ready !== (!m_busy && !wr_en)) begin
        failures++;
        $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, cmd_ready, !m_busy && !wr_en);
      end
      if (!m_busy) begin
        checks++;
        if (rd_data !== DW'(ref_r[rd_addr])) begin
          failures++;
          $display("FAIL rnd_reg cyc=%0d R%0d got=%h exp=%h", cyc, rd_addr, rd_data,
                   DW'(ref_r[rd_addr]));
        end
      end
      @(posedge clk);
      if (!m_busy) begin
        if (wr_en) begin
          ref_r[wr_addr] = int'(wr_data);
        end else if (cmd_valid) begin
          ref_alu(int'(cmd_op), ref_r[cmd_srca], ref_r[cmd_srcb], res, cout);
          exp_res = res;
          exp_cout = cout;
          ref_r[cmd_dst] = res;
          m_busy = 1;
          m_issue = 1;
          ncmd++;
        end
      end else if (m_issue) begin
        m_issue = 0;
        m_valid = 1;
      end else if (rsp_ready) begin
        m_valid = 0;
        m_busy = 0;
      end
      #1;
      cyc++;
      checks++;
      if (rsp_valid !== m_valid || busy !== m_busy) begin
        failures++;
        $display("FAIL rnd_state cyc=%0d got v=%b busy=%b exp v=%b busy=%b",
                 cyc, rsp_valid, busy, m_valid, m_busy);
      end
      if (m_valid) begin
        checks++;
        if (rsp_result !== DW'(exp_res) || rsp_cout !== 1'(exp_cout)) begin
          failures++;
          $display("FAIL rnd_rsp cyc=%0d got=%h/%b exp=%h/%0d", cyc, rsp_result, rsp_cout,
                   DW'(exp_res), exp_cout);
        end
      end
    end
    wr_en = 1'b0;
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    checks++;
    if (ncmd != NCMD) begin
      failures++;
      $display("FAIL rnd_timeout got=%0d cmds exp=%0d", ncmd, NCMD);
    end
    repeat (3) step();
    rsp_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add_carry();
    test_xor_backpressure();
    test_inc_chain();
    test_write_priority();
    test_reset_mid_op();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
